cic_integrator_chain: RTL and testbench

- Integrator section of a CIC decimation filter: a cascade of N_STAGES running-sum accumulators clocked at the full input rate.
- Sits between the input sample source (ADC/mixer) and the downstream decimator/comb section.
- Output is the most-significant OUTPUT_WIDTH bits of the last accumulator, registered.
- Signed two's-complement data throughout; wrap-around arithmetic is intentional, as CIC theory requires.

---
 rtl/cic_pkg.sv | 28 ++
 rtl/cic_int_stage.sv | 27 ++
 rtl/cic_integrator_chain.sv | 51 +++++
 tb/tb_cic_integrator_chain.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared constants and width helpers for the CIC integrator section.
// The defaults describe a 4-stage chain with R=32 and M=1.
package cic_pkg;

    localparam int DEF_INPUT_WIDTH  = 16;
    localparam int DEF_OUTPUT_WIDTH = 12;
    localparam int DEF_N_STAGES     = 4;
    localparam int DEF_GROWTH       = 20;

    // Ceiling log2, usable in constant expressions; clog2_f(1) == 0.
    function automatic int clog2_f(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Bit growth of an N-stage CIC with rate change R and differential delay M.
    function automatic int cic_growth_f(input int n_stages, input int rate, input int diff_delay);
        return n_stages * clog2_f(rate * diff_delay);
    endfunction

endpackage

// File: rtl/cic_int_stage.sv
// One CIC integrator: a signed running-sum register that wraps modulo 2^WIDTH.
// The wrap is deliberate; the comb section downstream cancels it.
module cic_int_stage
    import cic_pkg::*;
#(
    parameter int WIDTH = DEF_INPUT_WIDTH + DEF_GROWTH
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] d_in,
    output logic signed [WIDTH-1:0] acc
);

    logic signed [WIDTH-1:0] acc_r;

    // Accumulate the incoming value each cycle; reset clears the history.
    always_ff @(posedge clock) begin
        if (rst) begin
            acc_r <= {WIDTH{1'b0}};
        end else begin
            acc_r <= acc_r + d_in;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/cic_integrator_chain.sv
// Integrator section of a CIC decimator: N_STAGES cascaded accumulators at the
// input rate, followed by a registered truncation to the top OUTPUT_WIDTH bits.
module cic_integrator_chain
    import cic_pkg::*;
#(
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
    parameter int N_STAGES     = DEF_N_STAGES,
    parameter int GROWTH       = DEF_GROWTH
) (
    input  logic                           clock,
    input  logic                           rst,
    input  logic signed [INPUT_WIDTH-1:0]  d_in,
    output logic signed [OUTPUT_WIDTH-1:0] d_out
);

    localparam int ACC_WIDTH = INPUT_WIDTH + GROWTH;

    logic signed [ACC_WIDTH-1:0]    stage_in_s [N_STAGES];
    logic signed [ACC_WIDTH-1:0]    acc_s      [N_STAGES];
    logic signed [OUTPUT_WIDTH-1:0] d_out_r;

    // The size cast of a signed operand sign-extends the sample.
    assign stage_in_s[0] = ACC_WIDTH'(d_in);

    for (genvar g = 0; g < N_STAGES; g++) begin : g_stage
        if (g > 0) begin : g_link
            assign stage_in_s[g] = acc_s[g-1];
        end
        cic_int_stage #(
            .WIDTH (ACC_WIDTH)
        ) u_stage (
            .clock (clock),
            .rst   (rst),
            .d_in  (stage_in_s[g]),
            .acc   (acc_s[g])
        );
    end

    // Keep the MSBs of the last integrator; LSBs are dropped without rounding.
    always_ff @(posedge clock) begin
        if (rst) begin
            d_out_r <= {OUTPUT_WIDTH{1'b0}};
        end else begin
            d_out_r <= acc_s[N_STAGES-1][ACC_WIDTH-1 -: OUTPUT_WIDTH];
        end
    end

    assign d_out = d_out_r;

endmodule

// File: tb/tb_cic_integrator_chain.sv
// Self-checking bench: four differently parameterised chains run side by side,
// each compared every cycle against a prefix-sum model of its input history.
module tb_cic_integrator_chain;

    logic        clock = 1'b0;
    logic        rst_def, rst_imp, rst_step, rst_neg;
    logic [15:0] d_in_def, d_in_imp, d_in_step, d_in_neg;
    logic [11:0] d_out_def;
    logic [15:0] d_out_imp;
    logic [23:0] d_out_step;
    logic [19:0] d_out_neg;

    logic [63:0] h_def[$], h_imp[$], h_step[$], h_neg[$];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    cic_integrator_chain u_def (
        .clock (clock), .rst (rst_def), .d_in (d_in_def), .d_out (d_out_def)
    );
    cic_integrator_chain #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(16), .N_STAGES(1), .GROWTH(0)) u_imp (
        .clock (clock), .rst (rst_imp), .d_in (d_in_imp), .d_out (d_out_imp)
    );
    cic_integrator_chain #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(24), .N_STAGES(2), .GROWTH(8)) u_step (
        .clock (clock), .rst (rst_step), .d_in (d_in_step), .d_out (d_out_step)
    );
    cic_integrator_chain #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(20), .N_STAGES(1), .GROWTH(4)) u_neg (
        .clock (clock), .rst (rst_neg), .d_in (d_in_neg), .d_out (d_out_neg)
    );

    function automatic logic [63:0] sx(input logic [15:0] v);
        return {{48{v[15]}}, v};
    endfunction

    // d_out after edge E equals the top bits of the n-fold running sum
    // A_{n-1}(E-1), where A_0(e) = x(1)+..+x(e) and A_k(e) = A_{k-1}(0)+..+A_{k-1}(e-1).
    function automatic logic [63:0] ref_out(input logic [63:0] xs[$], input int n,
                                            input int accw, input int ow);
        logic [63:0] mask;
        logic [63:0] a[$];
        logic [63:0] b[$];
        int          e_cnt;
        mask  = (64'd1 << accw) - 64'd1;
        e_cnt = xs.size();
        if (e_cnt == 0) return 64'd0;
        a.push_back(64'd0);
        for (int e = 1; e <= e_cnt; e++) a.push_back((a[e-1] + xs[e-1]) & mask);
        for (int k = 1; k < n; k++) begin
            b.delete();
            b.push_back(64'd0);
            for (int e = 1; e <= e_cnt; e++) b.push_back((b[e-1] + a[e-1]) & mask);
            a = b;
        end
        return (a[e_cnt-1] >> (accw - ow)) & ((64'd1 << ow) - 64'd1);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge: record what each DUT sampled, then compare all outputs.
    task automatic step();
        @(posedge clock);
        if (rst_def)  h_def.delete();  else h_def.push_back(sx(d_in_def));
        if (rst_imp)  h_imp.delete();  else h_imp.push_back(sx(d_in_imp));
        if (rst_step) h_step.delete(); else h_step.push_back(sx(d_in_step));
        if (rst_neg)  h_neg.delete();  else h_neg.push_back(sx(d_in_neg));
        #1;
        check("def_model",  64'(d_out_def),  ref_out(h_def, 4, 36, 12));
        check("imp_model",  64'(d_out_imp),  ref_out(h_imp, 1, 16, 16));
        check("step_model", 64'(d_out_step), ref_out(h_step, 2, 24, 24));
        check("neg_model",  64'(d_out_neg),  ref_out(h_neg, 1, 20, 20));
    endtask

    initial begin
        logic [63:0] tri_exp  [7];
        logic [63:0] wrap_exp [5];
        tri_exp  = '{64'd0, 64'd0, 64'd1, 64'd3, 64'd6, 64'd10, 64'd15};
        wrap_exp = '{64'h4000, 64'h8000, 64'hC000, 64'h0000, 64'h4000};

        // Reset held with a large input present: output must stay zero.
        rst_def = 1'b1; rst_imp = 1'b1; rst_step = 1'b1; rst_neg = 1'b1;
        d_in_def = 16'h7FFF; d_in_imp = 16'h0000; d_in_step = 16'h0000; d_in_neg = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            step();
            check("reset_hold", 64'(d_out_def), 64'd0);
        end
        rst_def = 1'b0; rst_imp = 1'b0; rst_step = 1'b0; rst_neg = 1'b0;
        d_in_def = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_release", 64'(d_out_def), 64'd0);
        end

        // Impulse into a single integrator.
        rst_imp = 1'b1; step(); rst_imp = 1'b0;
        d_in_imp = 16'h0001; step();
        check("impulse_first", 64'(d_out_imp), 64'd0);
        d_in_imp = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            step();
            check("impulse_hold", 64'(d_out_imp), 64'd1);
        end

        // Unit step into two stages gives triangular numbers.
        rst_step = 1'b1; step(); rst_step = 1'b0;
        d_in_step = 16'h0001;
        for (int i = 0; i < 7; i++) begin
            step();
            check("step_tri", 64'(d_out_step), tri_exp[i]);
        end
        d_in_step = 16'h0000;

        // Constant 0x4000 wraps modulo 2^16.
        rst_imp = 1'b1; step(); rst_imp = 1'b0;
        d_in_imp = 16'h4000; step();
        check("wrap_first", 64'(d_out_imp), 64'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("wrap_seq", 64'(d_out_imp), wrap_exp[i]);
        end
        d_in_imp = 16'h0000;

        // Negative input is sign-extended into the wider accumulator.
        rst_neg = 1'b1; step(); rst_neg = 1'b0;
        d_in_neg = 16'hFFFF; step();
        step(); check("neg_m1", 64'(d_out_neg), 64'hFFFFF);
        step(); check("neg_m2", 64'(d_out_neg), 64'hFFFFE);
        d_in_neg = 16'h0000;
        step(); check("neg_m3", 64'(d_out_neg), 64'hFFFFD);

        // Ramp into the default four-stage chain.
        rst_def = 1'b1; step(); rst_def = 1'b0;
        for (int i = 0; i < 300; i++) begin
            d_in_def = 16'(i);
            step();
        end

        // Random full-scale samples everywhere, with a mid-stream reset.
        rst_def = 1'b1; rst_imp = 1'b1; rst_step = 1'b1; rst_neg = 1'b1;
        step();
        rst_def = 1'b0; rst_imp = 1'b0; rst_step = 1'b0; rst_neg = 1'b0;
        for (int i = 0; i < 200; i++) begin
            d_in_def  = 16'($urandom);
            d_in_imp  = 16'($urandom);
            d_in_step = 16'($urandom);
            d_in_neg  = 16'($urandom);
            if (i == 100) begin
                rst_def = 1'b1; rst_imp = 1'b1; rst_step = 1'b1; rst_neg = 1'b1;
            end else begin
                rst_def = 1'b0; rst_imp = 1'b0; rst_step = 1'b0; rst_neg = 1'b0;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
